// File: rtl/mem_wb_stage_if.sv
// EX/MEM-to-MEM/WB bundle for mem_wb_stage: pipeline inputs, branch
// resolution, stall back to the front end and the registered write-back result.
interface mem_wb_stage_if;
  logic        RegWriteEN_In;
  logic [1:0]  Mem2RegSEL_In;
  logic        MemWriteEN_In;
  logic        Beq_In;
  logic        Bne_In;
  logic        ZeroFlag_In;
  logic [31:0] ALUResult_In;
  logic [31:0] WriteData_In;
  logic [4:0]  RegWBAddr_In;
  logic [31:0] PCBranch_In;
  logic [31:0] PCPlus4_In;

  logic        PCSrc_Out;
  logic [31:0] PCBranch_Out;
  logic        Stall_Out;
  logic        RegWriteEN_Out;
  logic [4:0]  RegWBAddr_Out;
  logic [31:0] WBData_Out;

  modport master (
    output RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Beq_In, Bne_In,
           ZeroFlag_In, ALUResult_In, WriteData_In, RegWBAddr_In,
           PCBranch_In, PCPlus4_In,
    input  PCSrc_Out, PCBranch_Out, Stall_Out, RegWriteEN_Out,
           RegWBAddr_Out, WBData_Out
  );

  modport slave (
    input  RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Beq_In, Bne_In,
           ZeroFlag_In, ALUResult_In, WriteData_In, RegWBAddr_In,
           PCBranch_In, PCPlus4_In,
    output PCSrc_Out, PCBranch_Out, Stall_Out, RegWriteEN_Out,
           RegWBAddr_Out, WBData_Out
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB register: branch resolve, data memory, write-back select.
// Optional wait-state controller compiled in with `define MEM_WB_STAGE_WAIT_EN.
//
// state  | meaning
// S_IDLE | no access in flight; a new access starts stalling here
// S_WAIT | access stretched; cnt_q cycles of stall remain before commit
module mem_wb_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           CLOCK,
  input  logic           RESET_N,
  mem_wb_stage_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_rdata;
  logic          access;
  logic          stall;
  logic          commit;
  logic [31:0]   wb_sel;

  logic          rwe_q,    rwe_d;
  logic [4:0]    waddr_q,  waddr_d;
  logic [31:0]   wbdata_q, wbdata_d;

  logic          unused_addr_bits;
  assign unused_addr_bits = ^{bus.ALUResult_In[31:AW+2], bus.ALUResult_In[1:0]};

  assign bus.PCSrc_Out    = (bus.Beq_In & bus.ZeroFlag_In) | (bus.Bne_In & ~bus.ZeroFlag_In);
  assign bus.PCBranch_Out = bus.PCBranch_In;

  assign access    = bus.MemWriteEN_In | (bus.Mem2RegSEL_In == 2'b01);
  assign word_idx  = bus.ALUResult_In[AW+1:2];
  assign mem_rdata = mem_q[word_idx];

`ifdef MEM_WB_STAGE_WAIT_EN
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] CNT_START = 4'(WAIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && (WAIT_CYCLES != 0)) begin
          stall   = 1'b1;
          state_d = S_WAIT;
          cnt_d   = CNT_START;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  assign bus.Stall_Out = stall;
  assign commit        = ~stall;

  always_comb begin
    case (bus.Mem2RegSEL_In)
      2'b01:   wb_sel = mem_rdata;
      2'b10:   wb_sel = bus.PCPlus4_In;
      default: wb_sel = bus.ALUResult_In;
    endcase
  end

  // A stalled edge pushes a bubble so write-back never sees a half-done access.
  always_comb begin
    rwe_d    = 1'b0;
    waddr_d  = 5'd0;
    wbdata_d = 32'd0;
    if (commit) begin
      rwe_d    = bus.RegWriteEN_In;
      waddr_d  = bus.RegWBAddr_In;
      wbdata_d = wb_sel;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rwe_q    <= 1'b0;
      waddr_q  <= 5'd0;
      wbdata_q <= 32'd0;
    end else begin
      rwe_q    <= rwe_d;
      waddr_q  <= waddr_d;
      wbdata_q <= wbdata_d;
    end
  end

  // Data array is deliberately not reset.
  always_ff @(posedge CLOCK) begin
    if (commit && bus.MemWriteEN_In)
      mem_q[word_idx] <= bus.WriteData_In;
  end

  assign bus.RegWriteEN_Out = rwe_q;
  assign bus.RegWBAddr_Out  = waddr_q;
  assign bus.WBData_Out     = wbdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (wait-state checks follow MEM_WB_STAGE_WAIT_EN).
module tb_mem_wb_stage;

`ifdef MEM_WB_STAGE_WAIT_EN
  localparam int EXP_STALL = 3;
`else
  localparam int EXP_STALL = 0;
`endif

  logic CLOCK = 1'b0;
  logic RESET_N;
  int   tests_run = 0;
  int   tests_failed = 0;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic set_idle();
    bus.RegWriteEN_In = 1'b0;
    bus.Mem2RegSEL_In = 2'b00;
    bus.MemWriteEN_In = 1'b0;
    bus.Beq_In        = 1'b0;
    bus.Bne_In        = 1'b0;
    bus.ZeroFlag_In   = 1'b0;
    bus.ALUResult_In  = 32'd0;
    bus.WriteData_In  = 32'd0;
    bus.RegWBAddr_In  = 5'd0;
    bus.PCBranch_In   = 32'd0;
    bus.PCPlus4_In    = 32'd0;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] data);
    set_idle();
    bus.MemWriteEN_In = 1'b1;
    bus.ALUResult_In  = addr;
    bus.WriteData_In  = data;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
    set_idle();
    bus.RegWriteEN_In = 1'b1;
    bus.Mem2RegSEL_In = 2'b01;
    bus.ALUResult_In  = addr;
    bus.RegWBAddr_In  = rd;
  endtask

  // Clock until the instruction on the inputs commits (bounded); reports
  // stalled cycles and whether any stalled edge left a live write enable.
  task automatic step_commit(output int stalls, output bit bubble_bad);
    bit done = 1'b0;
    stalls = 0;
    bubble_bad = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (bus.Stall_Out !== 1'b1) begin
        @(posedge CLOCK); #1;
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge CLOCK); #1;
        if (bus.RegWriteEN_Out !== 1'b0) bubble_bad = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    set_idle();
    bus.RegWriteEN_In = 1'b1;
    RESET_N = 1'b0;
    #2;
    tests_run++;
    if ({bus.RegWriteEN_Out, bus.RegWBAddr_Out, bus.WBData_Out} !== 38'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b/%0d/%h expected 0/0/0",
               bus.RegWriteEN_Out, bus.RegWBAddr_Out, bus.WBData_Out);
    end
    @(negedge CLOCK); RESET_N = 1'b1;
    set_idle();
    @(posedge CLOCK); #1;
  endtask

  task automatic test_reset_mid_activity();
    int s; bit b;
    set_idle();
    bus.RegWriteEN_In = 1'b1;
    bus.RegWBAddr_In  = 5'd5;
    bus.ALUResult_In  = 32'h0000_0055;
    step_commit(s, b);
    tests_run++;
    if (bus.WBData_Out !== 32'h55 || bus.RegWriteEN_Out !== 1'b1) begin
      tests_failed++;
      $display("FAIL alu_wb: got %h/%b expected 00000055/1", bus.WBData_Out, bus.RegWriteEN_Out);
    end
    #2 RESET_N = 1'b0;
    #1;
    tests_run++;
    if ({bus.RegWriteEN_Out, bus.RegWBAddr_Out, bus.WBData_Out} !== 38'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got %b/%0d/%h expected 0/0/0",
               bus.RegWriteEN_Out, bus.RegWBAddr_Out, bus.WBData_Out);
    end
    @(negedge CLOCK); RESET_N = 1'b1;
    set_idle();
    @(posedge CLOCK); #1;
  endtask

  task automatic test_store_load();
    int s; bit b;
    drive_store(32'h10, 32'hDEAD_BEEF);
    step_commit(s, b);
    tests_run++;
    if (s != EXP_STALL || bus.RegWriteEN_Out !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_stall: got stalls=%0d we=%b expected %0d/0", s, bus.RegWriteEN_Out, EXP_STALL);
    end
    drive_load(32'h10, 5'd8);
    step_commit(s, b);
    tests_run++;
    if (bus.WBData_Out !== 32'hDEAD_BEEF || bus.RegWBAddr_Out !== 5'd8 || bus.RegWriteEN_Out !== 1'b1) begin
      tests_failed++;
      $display("FAIL store_load: got %h/%0d/%b expected deadbeef/8/1",
               bus.WBData_Out, bus.RegWBAddr_Out, bus.RegWriteEN_Out);
    end
    drive_load(32'h13, 5'd9);
    step_commit(s, b);
    tests_run++;
    if (bus.WBData_Out !== 32'hDEAD_BEEF || bus.RegWBAddr_Out !== 5'd9) begin
      tests_failed++;
      $display("FAIL byte_offset_ignored: got %h/%0d expected deadbeef/9", bus.WBData_Out, bus.RegWBAddr_Out);
    end
  endtask

  task automatic test_branch();
    set_idle();
    bus.PCBranch_In = 32'h0040_0020;
    bus.Beq_In = 1'b1; bus.ZeroFlag_In = 1'b1;
    #1;
    tests_run++;
    if (bus.PCSrc_Out !== 1'b1 || bus.PCBranch_Out !== 32'h0040_0020) begin
      tests_failed++;
      $display("FAIL beq_taken: got %b/%h expected 1/00400020", bus.PCSrc_Out, bus.PCBranch_Out);
    end
    bus.Beq_In = 1'b0; bus.Bne_In = 1'b1;
    #1;
    tests_run++;
    if (bus.PCSrc_Out !== 1'b0 || bus.PCBranch_Out !== 32'h0040_0020) begin
      tests_failed++;
      $display("FAIL bne_not_taken: got %b/%h expected 0/00400020", bus.PCSrc_Out, bus.PCBranch_Out);
    end
    bus.ZeroFlag_In = 1'b0;
    #1;
    tests_run++;
    if (bus.PCSrc_Out !== 1'b1) begin
      tests_failed++;
      $display("FAIL bne_taken: got %b expected 1", bus.PCSrc_Out);
    end
    bus.Bne_In = 1'b0; bus.Beq_In = 1'b1;
    #1;
    tests_run++;
    if (bus.PCSrc_Out !== 1'b0) begin
      tests_failed++;
      $display("FAIL beq_not_taken: got %b expected 0", bus.PCSrc_Out);
    end
    set_idle();
    @(posedge CLOCK); #1;
  endtask

  task automatic test_wrap();
    int s; bit b;
    drive_store(32'h400, 32'h0000_1234);
    step_commit(s, b);
    drive_load(32'h0, 5'd3);
    step_commit(s, b);
    tests_run++;
    if (bus.WBData_Out !== 32'h0000_1234) begin
      tests_failed++;
      $display("FAIL addr_wrap: got %h expected 00001234", bus.WBData_Out);
    end
  endtask

  task automatic test_wait();
    int s; bit b;
    drive_load(32'h10, 5'd4);
    step_commit(s, b);
    tests_run++;
    if (s != EXP_STALL || b) begin
      tests_failed++;
      $display("FAIL wait_stall_count: got %0d bubble_bad=%b expected %0d/0", s, b, EXP_STALL);
    end
    tests_run++;
    if (bus.WBData_Out !== 32'hDEAD_BEEF || bus.RegWriteEN_Out !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_commit: got %h/%b expected deadbeef/1", bus.WBData_Out, bus.RegWriteEN_Out);
    end
    drive_store(32'h20, 32'h1111_1111);
    step_commit(s, b);
    drive_store(32'h20, 32'h2222_2222);
    #1;
    @(posedge CLOCK); #1;
    RESET_N = 1'b0;
    #1;
    set_idle();
    @(posedge CLOCK); #1;
    @(negedge CLOCK); RESET_N = 1'b1;
    @(posedge CLOCK); #1;
    drive_load(32'h20, 5'd6);
    step_commit(s, b);
    tests_run++;
`ifdef MEM_WB_STAGE_WAIT_EN
    if (bus.WBData_Out !== 32'h1111_1111 || s != EXP_STALL) begin
      tests_failed++;
      $display("FAIL reset_aborts_store: got %h stalls=%0d expected 11111111/%0d", bus.WBData_Out, s, EXP_STALL);
    end
`else
    if (bus.WBData_Out !== 32'h2222_2222 || s != 0) begin
      tests_failed++;
      $display("FAIL store_single_edge: got %h stalls=%0d expected 22222222/0", bus.WBData_Out, s);
    end
`endif
  endtask

  task automatic test_jal();
    set_idle();
    bus.RegWriteEN_In = 1'b1;
    bus.Mem2RegSEL_In = 2'b10;
    bus.PCPlus4_In    = 32'h0040_0008;
    bus.ALUResult_In  = 32'h0000_0010;
    bus.RegWBAddr_In  = 5'd31;
    #1;
    tests_run++;
    if (bus.Stall_Out !== 1'b0) begin
      tests_failed++;
      $display("FAIL jal_no_stall: got %b expected 0", bus.Stall_Out);
    end
    @(posedge CLOCK); #1;
    tests_run++;
    if (bus.WBData_Out !== 32'h0040_0008 || bus.RegWBAddr_Out !== 5'd31 || bus.RegWriteEN_Out !== 1'b1) begin
      tests_failed++;
      $display("FAIL jal_wb: got %h/%0d/%b expected 00400008/31/1",
               bus.WBData_Out, bus.RegWBAddr_Out, bus.RegWriteEN_Out);
    end
    bus.Mem2RegSEL_In = 2'b11;
    bus.ALUResult_In  = 32'hA5A5_0003;
    @(posedge CLOCK); #1;
    tests_run++;
    if (bus.WBData_Out !== 32'hA5A5_0003) begin
      tests_failed++;
      $display("FAIL sel11_alu: got %h expected a5a50003", bus.WBData_Out);
    end
  endtask

  task automatic test_back_to_back();
    int s; bit b;
    drive_store(32'h24, 32'h0BAD_CAFE);
    step_commit(s, b);
    drive_load(32'h24, 5'd12);
    step_commit(s, b);
    tests_run++;
    if (bus.WBData_Out !== 32'h0BAD_CAFE || s != EXP_STALL) begin
      tests_failed++;
      $display("FAIL b2b_load1: got %h stalls=%0d expected 0badcafe/%0d", bus.WBData_Out, s, EXP_STALL);
    end
    drive_load(32'h0, 5'd13);
    step_commit(s, b);
    tests_run++;
    if (bus.WBData_Out !== 32'h0000_1234 || bus.RegWBAddr_Out !== 5'd13 || s != EXP_STALL) begin
      tests_failed++;
      $display("FAIL b2b_load2: got %h/%0d stalls=%0d expected 00001234/13/%0d",
               bus.WBData_Out, bus.RegWBAddr_Out, s, EXP_STALL);
    end
  endtask

  initial begin
    set_idle();
    RESET_N = 1'b1;
    test_reset();
    test_reset_mid_activity();
    test_store_load();
    test_branch();
    test_wrap();
    test_wait();
    test_jal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/MEM pipeline register. It resolves conditional branches and performs the data-memory load or store. It selects the write-back value and registers the result into the MEM/WB boundary. A wait-state controller can stretch memory accesses and stall the pipeline front end.

## Interface
- DEPTH_WORDS, 256: data-memory depth in 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 0: extra cycles per memory access (used only with the wait feature), 0–15.
- CLOCK  in  1  pipeline clock; all state changes on the rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- RegWriteEN_In  in  1  register write enable from EX/MEM.
- Mem2RegSEL_In  in  2  write-back select: 00 = ALU, 01 = memory read, 10 = PCPlus4, 11 = ALU.
- MemWriteEN_In  in  1  store enable.
- Beq_In, Bne_In  in  1 each  branch-type flags.
- ZeroFlag_In  in  1  ALU zero flag.
- ALUResult_In  in  32  ALU result / byte address.
- WriteData_In  in  32  store data.
- RegWBAddr_In  in  5  destination register.
- PCBranch_In  in  32  branch target.
- PCPlus4_In  in  32  return address.
- PCSrc_Out  out  1  branch taken (combinational).
- PCBranch_Out  out  32  PCBranch_In passed through (combinational).
- Stall_Out  out  1  hold PC, IF/ID, ID/EX and EX/MEM (combinational).
- RegWriteEN_Out  out  1  registered MEM/WB write enable.
- RegWBAddr_Out  out  5  registered MEM/WB destination.
- WBData_Out  out  32  registered write-back value.

## Operation
- PCSrc_Out = (Beq_In & ZeroFlag_In) | (Bne_In & ~ZeroFlag_In). It does not depend on stall or FSM state.
- Access condition: MemWriteEN_In | (Mem2RegSEL_In == 01).
- Word index: ALUResult_In[log2(DEPTH_WORDS)+1 : 2].
  - Bits [1:0] are ignored.
  - Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Memory read is combinational from the array.
- Memory write takes effect on the commit edge; memory contents are not reset.
- Commit edge = a rising edge where the access condition holds and Stall_Out = 0, or any edge with no access.
- On each commit edge:
  - RegWriteEN_Out ← RegWriteEN_In
  - RegWBAddr_Out ← RegWBAddr_In
  - WBData_Out ← value selected by Mem2RegSEL_In
- On a stalled edge (Stall_Out = 1), a bubble is inserted: RegWriteEN_Out ← 0, RegWBAddr_Out ← 0, WBData_Out ← 0, and no memory write occurs.
- Wait FSM (feature enabled, WAIT_CYCLES = N > 0):
  - IDLE, access present: Stall_Out = 1; next state WAIT, cnt ← N−1.
  - IDLE, no access: Stall_Out = 0; stay in IDLE.
  - WAIT, cnt ≠ 0: Stall_Out = 1; cnt ← cnt−1.
  - WAIT, cnt = 0: Stall_Out = 0; commit; next state IDLE.
  - cnt is 4 bits.
- Upstream holds all _In signals stable while Stall_Out = 1; the hazard unit guarantees this.
- Back-to-back accesses each pay the full N-cycle stall.
- A load immediately following a store to the same word reads the new data.
- A branch and an access in the same instruction are illegal; branch resolution is unaffected if it happens anyway.

## Timing
- Reset (RESET_N low, asynchronous): RegWriteEN_Out = 0, RegWBAddr_Out = 0, WBData_Out = 0, FSM = IDLE, cnt = 0.
- Reset asserted during WAIT aborts the access; the pending store is not performed.
- Reset does not affect PCSrc_Out or PCBranch_Out.
- Latency: one cycle from _In to the MEM/WB outputs for non-access instructions and for accesses with N = 0.
- Latency is N+1 cycles for accesses with N > 0.
- Stall_Out is high for exactly N consecutive cycles per access.

## Configuration
- MEM_WB_STAGE_WAIT_EN defined: the wait FSM and cnt are compiled in and WAIT_CYCLES applies.
- MEM_WB_STAGE_WAIT_EN undefined: no FSM or counter; Stall_Out is tied to 0, every access commits on the first edge, and WAIT_CYCLES is ignored.

## Test plan
- Reset mid-activity: assert RESET_N = 0 with RegWriteEN_In = 1 → all registered outputs 0 immediately (before any clock edge); FSM returns to IDLE.
- Store then load, N = 0: store 0xDEADBEEF at address 0x10, then load from 0x10 with Mem2RegSEL = 01 and RegWBAddr = 8 → on the next edge, WBData_Out = 0xDEADBEEF, RegWBAddr_Out = 8, RegWriteEN_Out = 1.
- Branch decode:
  - Beq = 1, Zero = 1 → PCSrc_Out = 1.
  - Bne = 1, Zero = 1 → PCSrc_Out = 0.
  - In both cases PCBranch_Out = PCBranch_In (e.g. 0x0040_0020).
- Address wrap, DEPTH_WORDS = 256: store 0x1234 at 0x400, then load from 0x0 → 0x1234.
- Wait states, macro defined, N = 3: load from 0x10.
  - Stall_Out is high for cycles 0–2 and RegWriteEN_Out = 0 during them.
  - On the commit at cycle 3, WBData_Out = memory data.
  - A reset asserted at cycle 1 of a store leaves the memory word unchanged.
- Jal write-back: Mem2RegSEL = 10, PCPlus4 = 0x0040_0008, RegWBAddr = 31 → WBData_Out = 0x0040_0008 with no stall, even when N = 3.
